// File: rtl/bit_stream_packer_pkg.sv
// Shared constants for the bit-stream packer and the population-counter bench.
package bit_stream_packer_pkg;

  localparam int unsigned BSP_DEFAULT_WIDTH = 16;

  // Width of a length field able to hold 0..w.
  function automatic int unsigned bsp_len_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/bit_stream_packer.sv
// Serial-to-parallel packer: gathers data_i bits into WIDTH-bit words and
// flushes a zero-padded partial word on last_i. Outputs are registered and
// pulse one cycle after the completing bit.
// Build option: BIT_STREAM_PACKER_LSB_FIRST_EN places the first bit of a word
// in data_o[0] (right-aligned partials); otherwise the first bit lands in
// data_o[WIDTH-1] (left-aligned partials).
module bit_stream_packer
  import bit_stream_packer_pkg::*;
#(
  parameter int unsigned WIDTH = BSP_DEFAULT_WIDTH
) (
  input  logic                              clk_i,
  input  logic                              srst_i,
  input  logic                              data_i,
  input  logic                              data_val_i,
  input  logic                              last_i,
  output logic [WIDTH-1:0]                  data_o,
  output logic                              data_val_o,
  output logic [bsp_len_width(WIDTH)-1:0]   data_len_o
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned LW = bsp_len_width(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  // cnt_q == 0 is the empty state; any other value means a word is filling.
  logic [CW-1:0]    cnt_q,  cnt_d;
  logic [WIDTH-1:0] sh_q,   sh_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [LW-1:0]    len_q,  len_d;
  logic             val_q,  val_d;

  logic [WIDTH-1:0] word;
  logic [CW-1:0]    idx;

  // Bits are written straight into their final slot, so the idle bits of the
  // cleared register already provide the zero padding of a partial flush.
  always_comb begin
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    data_d = data_q;
    len_d  = len_q;
    val_d  = 1'b0;
`ifdef BIT_STREAM_PACKER_LSB_FIRST_EN
    idx    = cnt_q;
`else
    idx    = CNT_MAX - cnt_q;
`endif
    word      = sh_q;
    word[idx] = data_i;
    if (data_val_i) begin
      if (cnt_q == CNT_MAX || last_i) begin
        data_d = word;
        len_d  = LW'(cnt_q) + LW'(1);
        val_d  = 1'b1;
        cnt_d  = '0;
        sh_d   = '0;
      end else begin
        sh_d  = word;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q  <= '0;
      sh_q   <= '0;
      data_q <= '0;
      len_q  <= '0;
      val_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      data_q <= data_d;
      len_q  <= len_d;
      val_q  <= val_d;
    end
  end

  assign data_o     = data_q;
  assign data_len_o = len_q;
  assign data_val_o = val_q;

endmodule

// File: tb/tb_bit_stream_packer.sv
// Directed bench for bit_stream_packer at WIDTH=8; expected words follow the
// BIT_STREAM_PACKER_LSB_FIRST_EN setting of the build.
module tb_bit_stream_packer;
  import bit_stream_packer_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned LW = bsp_len_width(W);

`ifdef BIT_STREAM_PACKER_LSB_FIRST_EN
  localparam logic [7:0] EXP_B2 = 8'h4D;
  localparam logic [7:0] EXP_E0 = 8'h07;
  localparam logic [7:0] EXP_0F = 8'hF0;
`else
  localparam logic [7:0] EXP_B2 = 8'hB2;
  localparam logic [7:0] EXP_E0 = 8'hE0;
  localparam logic [7:0] EXP_0F = 8'h0F;
`endif

  logic          clk = 1'b0;
  logic          srst_i = 1'b1;
  logic          data_i = 1'b0;
  logic          data_val_i = 1'b0;
  logic          last_i = 1'b0;
  logic [W-1:0]  data_o;
  logic          data_val_o;
  logic [LW-1:0] data_len_o;

  int checks = 0;
  int failures = 0;

  // reference model state
  int         m_n = 0;
  logic [7:0] m_acc = '0;

  bit_stream_packer #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .srst_i     (srst_i),
    .data_i     (data_i),
    .data_val_i (data_val_i),
    .last_i     (last_i),
    .data_o     (data_o),
    .data_val_o (data_val_o),
    .data_len_o (data_len_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic d, input logic v, input logic l);
    data_i     = d;
    data_val_i = v;
    last_i     = l;
    @(posedge clk);
    #1;
    data_val_i = 1'b0;
    last_i     = 1'b0;
  endtask

  task automatic expect_word(input string tag, input logic [7:0] w, input int unsigned len);
    chk({tag, "_val"}, 32'(data_val_o), 32'd1);
    chk({tag, "_data"}, 32'(data_o), 32'(w));
    chk({tag, "_len"}, 32'(data_len_o), 32'(len));
  endtask

  // Shift-style model: MSB-first shifts bits in from the right and
  // left-aligns partials on flush; LSB-first ORs each bit at its count.
  task automatic model_step(input string tag, input logic d, input logic v, input logic l);
    logic [7:0] w;
    step(d, v, l);
    if (v) begin
`ifdef BIT_STREAM_PACKER_LSB_FIRST_EN
      m_acc = m_acc | (8'(d) << m_n);
`else
      m_acc = {m_acc[6:0], d};
`endif
      m_n++;
      if (m_n == 8 || l) begin
`ifdef BIT_STREAM_PACKER_LSB_FIRST_EN
        w = m_acc;
`else
        w = m_acc << (8 - m_n);
`endif
        expect_word(tag, w, m_n);
        m_n   = 0;
        m_acc = '0;
        return;
      end
    end
    chk({tag, "_idle"}, 32'(data_val_o), 32'd0);
  endtask

  initial begin
    logic [7:0] pat;

    // reset state
    step(0, 0, 0);
    step(0, 0, 0);
    srst_i = 1'b0;
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_len", 32'(data_len_o), 32'd0);
    chk("rst_val", 32'(data_val_o), 32'd0);

    // full word 1,0,1,1,0,0,1,0
    pat = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      step(pat[7-i], 1, 0);
      if (i < 7) chk("b2_wait", 32'(data_val_o), 32'd0);
    end
    expect_word("b2", EXP_B2, 8);
    step(0, 0, 0);
    chk("hold_val", 32'(data_val_o), 32'd0);
    chk("hold_data", 32'(data_o), 32'(EXP_B2));
    chk("hold_len", 32'(data_len_o), 32'd8);

    // last_i without data_val_i is ignored
    step(1, 0, 1);
    chk("last_noval", 32'(data_val_o), 32'd0);

    // 3-bit frame
    step(1, 1, 0);
    step(1, 1, 0);
    chk("e0_wait", 32'(data_val_o), 32'd0);
    step(1, 1, 1);
    expect_word("e0", EXP_E0, 3);
    step(0, 0, 0);
    chk("e0_single", 32'(data_val_o), 32'd0);

    // 16 continuous ones: pulses after bit 8 and bit 16 only
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 0);
      if (i % 8 == 7) expect_word("ff", 8'hFF, 8);
      else chk("ff_gap", 32'(data_val_o), 32'd0);
    end

    // last_i on the 8th bit: exactly one full word
    pat = 8'h5A;
    for (int i = 0; i < 8; i++) step(pat[7-i], 1, (i == 7) ? 1'b1 : 1'b0);
    expect_word("last8", 8'h5A, 8);
    step(0, 0, 0);
    chk("last8_nox1", 32'(data_val_o), 32'd0);
    step(0, 0, 0);
    chk("last8_nox2", 32'(data_val_o), 32'd0);

    // mid-word reset, with data_val_i and last_i asserted alongside
    for (int i = 0; i < 5; i++) step(1, 1, 0);
    srst_i = 1'b1;
    step(1, 1, 1);
    srst_i = 1'b0;
    chk("mrst_val", 32'(data_val_o), 32'd0);
    chk("mrst_data", 32'(data_o), 32'd0);
    chk("mrst_len", 32'(data_len_o), 32'd0);
    pat = 8'h0F;
    for (int i = 0; i < 8; i++) begin
      step(pat[7-i], 1, 0);
      if (i < 7) chk("0f_wait", 32'(data_val_o), 32'd0);
    end
    expect_word("0f", EXP_0F, 8);

    // random gaps against the model, then a 1-bit frame
    m_n   = 0;
    m_acc = '0;
    for (int i = 0; i < 80; i++)
      model_step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 8 && m_n != 0; i++)
      model_step("rnd_fill", 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    chk("rnd_aligned", 32'(m_n), 32'd0);
    model_step("one_bit", 1'b1, 1'b1, 1'b1);
    chk("one_bit_len", 32'(data_len_o), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
